mux_2to1: RTL and testbench

//   2:1 selector with a purely combinational data path and an optional registered copy.
//   Y forwards A when S=0 and B when S=1, with no clock dependency.

---
 rtl/mux_2to1.sv | 63 ++++++
 tb/tb_mux_2to1.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
// 2:1 selector: combinational output Y plus a registered copy, registered select
// and a saturating count of select transitions for debug visibility.
module mux_2to1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    input  logic             en,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_r,
    output logic             sel_r,
    output logic [CNT_W-1:0] sw_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] y_r_q, y_r_d;
    logic             sel_r_q, sel_r_d;
    logic             s_prev_q, s_prev_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;

    // Plain conditional keeps X-select merging: bits where A==B still resolve.
    assign Y = S ? B : A;

    always_comb begin
        y_r_d    = y_r_q;
        sel_r_d  = sel_r_q;
        s_prev_d = S;
        sw_cnt_d = sw_cnt_q;
        if (en) begin
            y_r_d   = Y;
            sel_r_d = S;
        end
        if (S != s_prev_q) begin
            sw_cnt_d = sat_inc(sw_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_r_q    <= '0;
            sel_r_q  <= 1'b0;
            s_prev_q <= 1'b0;
            sw_cnt_q <= '0;
        end else begin
            y_r_q    <= y_r_d;
            sel_r_q  <= sel_r_d;
            s_prev_q <= s_prev_d;
            sw_cnt_q <= sw_cnt_d;
        end
    end

    assign Y_r    = y_r_q;
    assign sel_r  = sel_r_q;
    assign sw_cnt = sw_cnt_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Bench for mux_2to1: directed steps then randomized traffic on three instances
// (WIDTH=1/CNT_W=8, WIDTH=1/CNT_W=2 sharing inputs, WIDTH=8/CNT_W=8).
module tb_mux_2to1;

    logic clk = 1'b0;
    logic clk_run = 1'b0;

    logic       a1, b1, s1, en1, rst1;
    logic       y1, yr1, sel1, y2, yr2, sel2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    logic [7:0] a8, b8, y8, yr8, cnt8;
    logic       s8, en8, rst8, sel8;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m1_yr, m1_sel, m1_sprev;
    int         nsw1;
    logic [7:0] m8_yr;
    logic       m8_sel, m8_sprev;
    int         nsw8;

    mux_2to1 #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst1), .A(a1), .B(b1), .S(s1), .en(en1),
        .Y(y1), .Y_r(yr1), .sel_r(sel1), .sw_cnt(cnt1));

    mux_2to1 #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst1), .A(a1), .B(b1), .S(s1), .en(en1),
        .Y(y2), .Y_r(yr2), .sel_r(sel2), .sw_cnt(cnt2));

    mux_2to1 #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst8), .A(a8), .B(b8), .S(s8), .en(en8),
        .Y(y8), .Y_r(yr8), .sel_r(sel8), .sw_cnt(cnt8));

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic model_edge();
        if (rst1) begin
            m1_yr = 1'b0; m1_sel = 1'b0; m1_sprev = 1'b0; nsw1 = 0;
        end else begin
            if (en1) begin
                m1_yr  = s1 ? b1 : a1;
                m1_sel = s1;
            end
            if (s1 !== m1_sprev) nsw1++;
            m1_sprev = s1;
        end
        if (rst8) begin
            m8_yr = 8'h00; m8_sel = 1'b0; m8_sprev = 1'b0; nsw8 = 0;
        end else begin
            if (en8) begin
                m8_yr  = s8 ? b8 : a8;
                m8_sel = s8;
            end
            if (s8 !== m8_sprev) nsw8++;
            m8_sprev = s8;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_comb();
        check("y1", 64'(y1), 64'(s1 ? b1 : a1));
        check("y2", 64'(y2), 64'(s1 ? b1 : a1));
        check("y8", 64'(y8), 64'(s8 ? b8 : a8));
    endtask

    task automatic check_regs();
        check("yr1",  64'(yr1),  64'(m1_yr));
        check("sel1", 64'(sel1), 64'(m1_sel));
        check("cnt1", 64'(cnt1), 64'(sat(nsw1, 255)));
        check("yr2",  64'(yr2),  64'(m1_yr));
        check("sel2", 64'(sel2), 64'(m1_sel));
        check("cnt2", 64'(cnt2), 64'(sat(nsw1, 3)));
        check("yr8",  64'(yr8),  64'(m8_yr));
        check("sel8", 64'(sel8), 64'(m8_sel));
        check("cnt8", 64'(cnt8), 64'(sat(nsw8, 255)));
    endtask

    initial begin
        logic [7:0] y8_exp;

        // Combinational truth table with clock idle and rst/en undriven
        a1 = 1'b0; b1 = 1'b0; s1 = 1'b0; #10; check("tt_000", 64'(y1), 64'(1'b0));
        a1 = 1'b0; b1 = 1'b1; s1 = 1'b0; #10; check("tt_010", 64'(y1), 64'(1'b0));
        a1 = 1'b1; b1 = 1'b0; s1 = 1'b1; #10; check("tt_101", 64'(y1), 64'(1'b0));
        a1 = 1'b1; b1 = 1'b1; s1 = 1'b1; #10; check("tt_111", 64'(y1), 64'(1'b1));

        // Unknown select: agreeing bits resolve, differing bits go X
        a8 = 8'hF0; b8 = 8'hF5; s8 = 1'bx; #10;
        y8_exp = 8'b1111_0x0x;
        check("sel_x", 64'(y8), 64'(y8_exp));

        // Reset
        clk_run = 1'b1;
        a1 = 1'b1; b1 = 1'b0; s1 = 1'b0; en1 = 1'b1; rst1 = 1'b1;
        a8 = 8'h00; b8 = 8'h00; s8 = 1'b0; en8 = 1'b1; rst8 = 1'b1;
        tick();
        check_regs();
        check("rst_y", 64'(y1), 64'(1'b1));

        // Registered path and enable hold
        rst1 = 1'b0; en1 = 1'b1; a1 = 1'b1; b1 = 1'b0; s1 = 1'b1;
        tick();
        check("reg_yr", 64'(yr1), 64'(1'b0));
        check("reg_sel", 64'(sel1), 64'(1'b1));
        en1 = 1'b0; s1 = 1'b0; #1;
        check("hold_y", 64'(y1), 64'(1'b1));
        tick();
        check("hold_yr", 64'(yr1), 64'(1'b0));
        check("hold_sel", 64'(sel1), 64'(1'b1));
        check_regs();

        // Switch count: 5 toggles then 3 steady edges
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s1 = (i % 2 == 0);
            tick();
        end
        check("cnt5", 64'(cnt1), 64'(8'd5));
        check("cnt5_sat2", 64'(cnt2), 64'(2'd3));
        for (int i = 0; i < 3; i++) tick();
        check("cnt5_hold", 64'(cnt1), 64'(8'd5));
        check_regs();

        // Saturation on the 2-bit counter
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        check("cnt_clr", 64'(cnt2), 64'(2'd0));
        for (int i = 0; i < 6; i++) begin
            s1 = (i % 2 == 0);
            tick();
            check_regs();
        end
        check("sat3", 64'(cnt2), 64'(2'd3));
        check("cnt6", 64'(cnt1), 64'(8'd6));
        s1 = ~s1; tick(); s1 = ~s1; tick();
        check("sat3_hold", 64'(cnt2), 64'(2'd3));

        // Reset together with an S change: no count
        rst1 = 1'b1; s1 = ~s1; tick();
        check("rst_sw", 64'(cnt1), 64'(8'd0));
        rst1 = 1'b0; s1 = 1'b0;

        // 8-bit data and mid-run reset
        rst8 = 1'b0; en8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0; #1;
        check("w8_a", 64'(y8), 64'(8'hA5));
        s8 = 1'b1; #1;
        check("w8_b", 64'(y8), 64'(8'h3C));
        tick(); s8 = 1'b0; tick(); s8 = 1'b1; tick();
        check_regs();
        rst8 = 1'b1; tick();
        check("w8_rst_y", 64'(y8), 64'(8'h3C));
        check("w8_rst_cnt", 64'(cnt8), 64'(8'd0));
        check("w8_rst_yr", 64'(yr8), 64'(8'h00));
        rst8 = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); s1 = 1'($urandom);
            en1 = 1'($urandom); rst1 = ($urandom_range(15, 0) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            en8 = 1'($urandom); rst8 = ($urandom_range(15, 0) == 0);
            #1;
            check_comb();
            tick();
            check_regs();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
